// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU/MD opcodes and MD state type
package alu_pkg;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_LUI1 = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SLL1 = 4'b1111;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_md_if.sv
// rtl/alu_md_if.sv - request/result bundle between control unit and alu_md
interface alu_md_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, r, zero, carry, negative, overflow, hi, lo
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, r, zero, carry, negative, overflow, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO
module md_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state;
  logic [SHW:0]       cnt;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               start_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_upper;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;

  // Even op codes are the signed variants; magnitudes of MIN wrap to 2^(WIDTH-1), which is correct unsigned
  assign start_signed = ~md_op[0];
  assign a_mag        = (start_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag        = (start_signed && b[WIDTH-1]) ? -b : b;

  // acc_lo holds the multiplier (shifted out right) or the dividend (shifted out left)
  assign mul_upper = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
  assign trial     = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, m_q};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Sign fix and divide-by-zero override, applied to the finished magnitudes
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    prod     = {acc_hi, acc_lo};
    prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (b_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_lo = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
      res_hi = a_neg ? -acc_hi : acc_hi;
    end
  end

  // IDLE -> CALC (WIDTH iterations) -> DONE, HI/LO written only on leaving DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      a_q    <= '0;
      m_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            cnt    <= '0;
            is_div <= md_op[1];
            a_neg  <= start_signed & a[WIDTH-1];
            b_neg  <= start_signed & b[WIDTH-1];
            b_zero <= (b == '0);
            a_q    <= a;
            m_q    <= md_op[1] ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= md_op[1] ? a_mag : b_mag;
          end
        end
        CALC: begin
          if (!is_div) begin
            {acc_hi, acc_lo} <= {mul_upper, acc_lo[WIDTH-1:1]};
          end else if (!trial[WIDTH+1]) begin
            acc_hi <= trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == (SHW+1)'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - execute-stage unit: registered ALU plus iterative MD engine
module alu_md
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_md_if.slave  bus
);

  logic             fire;
  logic             alu_fire;
  logic             md_start;
  logic             nop_fire;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_res_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [3:0]       aluc;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   sll_ext;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] alu_r;
  logic             alu_z;
  logic             alu_c;
  logic             alu_n;
  logic             alu_v;

  assign bus.in_ready = ~md_busy;
  assign fire         = bus.in_valid & ~md_busy;
  assign alu_fire     = fire & ~bus.op[4];
  assign md_start     = fire & bus.op[4] & (bus.op[3:2] == 2'b00);
  assign nop_fire     = fire & bus.op[4] & (bus.op[3:2] != 2'b00);
  assign bus.hi       = md_hi;
  assign bus.lo       = md_lo;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .md_op  (bus.op[1:0]),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (md_busy),
    .done   (md_done),
    .res_lo (md_res_lo),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  assign aluc    = bus.op[3:0];
  assign sh      = bus.a[SHW-1:0];
  assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff    = {1'b0, bus.a} - {1'b0, bus.b};
  assign sll_ext = {1'b0, bus.b} << sh;
  assign lt_s    = $signed(bus.a) < $signed(bus.b);
  assign lt_u    = bus.a < bus.b;

  // Combinational ALU: result first, then per-op flag overrides
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (aluc)
      ALU_ADDU: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      ALU_SUBU: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
      end
      ALU_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_r = diff[WIDTH-1:0];
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_AND:            alu_r = bus.a & bus.b;
      ALU_OR:             alu_r = bus.a | bus.b;
      ALU_XOR:            alu_r = bus.a ^ bus.b;
      ALU_NOR:            alu_r = ~(bus.a | bus.b);
      ALU_LUI, ALU_LUI1:  alu_r = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLTU: begin
        alu_r = {{(WIDTH-1){1'b0}}, lt_u};
        alu_c = lt_u;
      end
      ALU_SLT:            alu_r = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SRA: begin
        alu_r = WIDTH'($signed(bus.b) >>> sh);
        alu_c = (sh != '0) & bus.b[WIDTH-1];
      end
      ALU_SRL:            alu_r = bus.b >> sh;
      ALU_SLL, ALU_SLL1: begin
        alu_r = sll_ext[WIDTH-1:0];
        alu_c = sll_ext[WIDTH];
      end
      default:            alu_r = '0;
    endcase
    alu_z = (alu_r == '0);
    alu_n = alu_r[WIDTH-1];
    if (aluc == ALU_SLTU || aluc == ALU_SLT) begin
      alu_z = (bus.a == bus.b);
      alu_n = (aluc == ALU_SLT) ? lt_s : 1'b0;
    end
  end

  // Output register: ALU result on acceptance, MD lo on completion, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.r         <= '0;
      bus.zero      <= 1'b0;
      bus.carry     <= 1'b0;
      bus.negative  <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.out_valid <= alu_fire | nop_fire | md_done;
      if (alu_fire) begin
        bus.r        <= alu_r;
        bus.zero     <= alu_z;
        bus.carry    <= alu_c;
        bus.negative <= alu_n;
        bus.overflow <= alu_v;
      end else if (md_done) begin
        bus.r        <= md_res_lo;
        bus.zero     <= (md_res_lo == '0);
        bus.carry    <= 1'b0;
        bus.negative <= 1'b0;
        bus.overflow <= 1'b0;
      end
    end
  end

endmodule
